// File: rtl/countdown_timer_pkg.sv
// Shared constants and state encoding for the countdown timer.
package countdown_timer_pkg;

    localparam int unsigned WidthDefault = 32;
    localparam int unsigned PeriodsWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, control levels and status outputs of the countdown timer.
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
);

    logic                    load_valid;
    logic                    load_ready;
    logic [WIDTH-1:0]        load_value;
    logic                    auto_reload;
    logic                    pause;
    logic                    abort;
    logic [WIDTH-1:0]        count;
    logic                    busy;
    logic                    expired;
    logic [PeriodsWidth-1:0] periods;

    // Requester side: offers loads and drives the control levels.
    modport master (
        output load_valid, load_value, auto_reload, pause, abort,
        input  load_ready, count, busy, expired, periods
    );

    // Timer side.
    modport slave (
        input  load_valid, load_value, auto_reload, pause, abort,
        output load_ready, count, busy, expired, periods
    );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/periodic modes, pause (hold) and abort.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input logic              clk,
    input logic              rst_n,
    countdown_timer_if.slave timer_io
);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic [WIDTH-1:0]        reload_q, reload_d;
    logic                    mode_q, mode_d;
    logic [PeriodsWidth-1:0] periods_q, periods_d;
    logic                    expired_q, expired_d;
    logic                    busy_q, busy_d;

    logic load_accept;
    logic last_cycle;

    assign load_accept = timer_io.load_valid && (state_q == StIdle);
    // A running count of 1 means the period completes at this edge.
    assign last_cycle  = (count_q == WIDTH'(1));

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        periods_d = periods_q;
        expired_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // abort has no meaning here, so it never blocks a load.
                if (load_accept) begin
                    reload_d  = timer_io.load_value;
                    mode_d    = timer_io.auto_reload;
                    count_d   = timer_io.load_value;
                    periods_d = '0;
                    if (timer_io.load_value == '0) begin
                        // A zero period completes on its own load edge.
                        expired_d = 1'b1;
                        periods_d = PeriodsWidth'(1);
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun, StHold: begin
                if (timer_io.abort) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (timer_io.pause) begin
                    state_d = StHold;
                end else if (last_cycle) begin
                    expired_d = 1'b1;
                    periods_d = periods_q + PeriodsWidth'(1);
                    if (mode_q) begin
                        state_d = StRun;
                        count_d = reload_q;
                    end else begin
                        state_d = StIdle;
                        count_d = '0;
                    end
                end else begin
                    // Leaving HOLD also decrements on the same edge.
                    state_d = StRun;
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            periods_q <= '0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            periods_q <= periods_d;
            expired_q <= expired_d;
            busy_q    <= busy_d;
        end
    end

    assign timer_io.load_ready = (state_q == StIdle);
    assign timer_io.count      = count_q;
    assign timer_io.busy       = busy_q;
    assign timer_io.expired    = expired_q;
    assign timer_io.periods    = periods_q;

endmodule
